// File: rtl/quad_enc_pkg.sv
// Shared A/B state encodings, step classification and signed saturation
// used by the quadrature encoder front end.
package quad_enc_pkg;

    localparam logic [1:0] STEP_0 = 2'b00;
    localparam logic [1:0] STEP_1 = 2'b01;
    localparam logic [1:0] STEP_2 = 2'b10;
    localparam logic [1:0] STEP_3 = 2'b11;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DOWN    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
    function automatic step_t decode_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
        step_t res;
        res = STEP_NONE;
        case ({old_ab, new_ab})
            {STEP_0, STEP_1}, {STEP_1, STEP_3},
            {STEP_3, STEP_2}, {STEP_2, STEP_0}: res = STEP_UP;
            {STEP_1, STEP_0}, {STEP_3, STEP_1},
            {STEP_2, STEP_3}, {STEP_0, STEP_2}: res = STEP_DOWN;
            {STEP_0, STEP_3}, {STEP_3, STEP_0},
            {STEP_1, STEP_2}, {STEP_2, STEP_1}: res = STEP_ILLEGAL;
            default:                            res = STEP_NONE;
        endcase
        return res;
    endfunction

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                      input int unsigned     w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 32'd1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: synchroniser, stability filter, 4x decode, position
// counter, sticky illegal-transition flag and windowed speed accumulator.
module quad_enc_channel #(
    parameter int COUNT_W    = 16,
    parameter int SPEED_W    = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         enc_ab_i,
    input  logic               count_clear_i,
    input  logic               error_clear_i,
    input  logic               window_end_i,
    output logic [COUNT_W-1:0] enc_count_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic               enc_error_o
);
    import quad_enc_pkg::*;

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam int ACC_W = SPEED_W + 1;

    logic [1:0]                s1_q, s2_q, prev_q;
    logic [1:0]                filt_q, filt_d;
    logic [CNT_W-1:0]          stable_q, stable_d;
    logic [COUNT_W-1:0]        count_q, count_d;
    logic                      err_q, err_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SPEED_W-1:0] speed_q, speed_d;
    step_t                     step_s;
    int                        run_s;
    logic signed [31:0]        step_val_s;
    logic signed [31:0]        sum_s;

    // Filter: a new A/B value is accepted only after FILTER_LEN agreeing samples.
    always_comb begin
        filt_d   = filt_q;
        stable_d = stable_q;
        step_s   = STEP_NONE;
        run_s    = 1;
        if (s2_q == filt_q) begin
            stable_d = '0;
        end else begin
            if (s2_q == prev_q) begin
                run_s = 32'(stable_q) + 1;
            end else begin
                run_s = 1;
            end
            if (run_s >= FILTER_LEN) begin
                filt_d   = s2_q;
                stable_d = '0;
                step_s   = decode_step(filt_q, s2_q);
            end else begin
                stable_d = CNT_W'(run_s);
            end
        end
    end

    // Position, sticky error and speed accumulation for the decoded step.
    always_comb begin
        count_d    = count_q;
        err_d      = err_q;
        acc_d      = acc_q;
        speed_d    = speed_q;
        step_val_s = 32'sd0;
        case (step_s)
            STEP_UP:   step_val_s = 32'sd1;
            STEP_DOWN: step_val_s = -32'sd1;
            default:   step_val_s = 32'sd0;
        endcase
        sum_s = 32'(acc_q) + step_val_s;

        if (count_clear_i) begin
            count_d = '0;
        end else if (step_s == STEP_UP) begin
            count_d = count_q + COUNT_W'(1'b1);
        end else if (step_s == STEP_DOWN) begin
            count_d = count_q - COUNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end

        // A fresh illegal transition outranks a simultaneous clear.
        if (step_s == STEP_ILLEGAL) begin
            err_d = 1'b1;
        end else if (error_clear_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (window_end_i) begin
            speed_d = SPEED_W'(sat_signed(sum_s, SPEED_W));
            acc_d   = '0;
        end else begin
            speed_d = speed_q;
            acc_d   = ACC_W'(sat_signed(sum_s, ACC_W));
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 2'b00;
            s2_q     <= 2'b00;
            prev_q   <= 2'b00;
            filt_q   <= 2'b00;
            stable_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            speed_q  <= '0;
        end else begin
            s1_q     <= enc_ab_i;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            filt_q   <= filt_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            speed_q  <= speed_d;
        end
    end

    assign enc_count_o = count_q;
    assign speed_o     = speed_q;
    assign enc_error_o = err_q;

endmodule

// File: rtl/quad_encoder_speed.sv
// Multi-channel quadrature encoder front end: position, illegal-transition
// flags and per-window signed speed, with one window timer shared by all channels.
module quad_encoder_speed #(
    parameter int NUM_CH        = 4,
    parameter int COUNT_W       = 16,
    parameter int SPEED_W       = 16,
    parameter int WINDOW_CYCLES = 50000,
    parameter int FILTER_LEN    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*NUM_CH-1:0]       enc,
    input  logic [NUM_CH-1:0]         count_clear,
    input  logic [NUM_CH-1:0]         error_clear,
    output logic [NUM_CH*COUNT_W-1:0] enc_count,
    output logic [NUM_CH*SPEED_W-1:0] speed,
    output logic                      speed_valid,
    output logic [NUM_CH-1:0]         enc_error
);
    import quad_enc_pkg::*;

    localparam int               TIMER_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               window_end_s;
    logic               valid_q;

    // Window timer wraps on its terminal count; that edge latches every speed field.
    always_comb begin
        window_end_s = (timer_q == TIMER_LAST);
        if (window_end_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1'b1);
        end
    end

    // Timer and speed_valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            valid_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            valid_q <= window_end_s;
        end
    end

    assign speed_valid = valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        quad_enc_channel #(
            .COUNT_W    (COUNT_W),
            .SPEED_W    (SPEED_W),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clk_i         (clk),
            .rst_i         (reset),
            .enc_ab_i      (enc[2*i +: 2]),
            .count_clear_i (count_clear[i]),
            .error_clear_i (error_clear[i]),
            .window_end_i  (window_end_s),
            .enc_count_o   (enc_count[i*COUNT_W +: COUNT_W]),
            .speed_o       (speed[i*SPEED_W +: SPEED_W]),
            .enc_error_o   (enc_error[i])
        );
    end

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Directed bench for quad_encoder_speed with a behavioural reference model
// compared on every falling clock edge, plus hand-computed spot values.
module tb_quad_encoder_speed;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int SW  = 4;
    localparam int WIN = 100;
    localparam int L   = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [2*NCH-1:0]    enc = '0;
    logic [NCH-1:0]      count_clear = '0;
    logic [NCH-1:0]      error_clear = '0;
    logic [NCH*CW-1:0]   enc_count;
    logic [NCH*SW-1:0]   speed;
    logic                speed_valid;
    logic [NCH-1:0]      enc_error;

    int checks = 0;
    int errors = 0;

    quad_encoder_speed #(
        .NUM_CH(NCH), .COUNT_W(CW), .SPEED_W(SW), .WINDOW_CYCLES(WIN), .FILTER_LEN(L)
    ) dut (
        .clk(clk), .reset(reset), .enc(enc), .count_clear(count_clear),
        .error_clear(error_clear), .enc_count(enc_count), .speed(speed),
        .speed_valid(speed_valid), .enc_error(enc_error)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_cnt[NCH];
    int         m_err[NCH];
    int         m_acc[NCH];
    int         m_speed[NCH];
    int         m_valid;
    int         m_timer;
    logic [1:0] m_f[NCH];
    logic [1:0] m_hist[NCH][$];

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, c, act, exp, $time);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_next(input logic [1:0] ab, input bit up);
        logic [1:0] tbl [4];
        tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11; tbl[3] = 2'b10;
        return tbl[(gidx(ab) + (up ? 1 : 3)) % 4];
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_err[c] = 0; m_acc[c] = 0; m_speed[c] = 0; m_f[c] = 2'b00;
            m_hist[c] = {};
            for (int j = 0; j <= L; j++) m_hist[c].push_back(2'b00);
        end
        m_valid = 0;
        m_timer = 0;
    endtask

    // m_hist[c][0..L-1] are the last L synchronised samples, m_hist[c][L] is still one stage behind.
    task automatic model_step();
        bit term;
        term = (m_timer == WIN - 1);
        for (int c = 0; c < NCH; c++) begin
            logic [1:0] x;
            bit ok;
            bit illegal;
            int d;
            int sv;
            x = m_hist[c][0];
            ok = (x != m_f[c]);
            for (int j = 1; j < L; j++) if (m_hist[c][j] != x) ok = 0;
            sv = 0;
            illegal = 0;
            if (ok) begin
                d = (gidx(x) - gidx(m_f[c]) + 4) % 4;
                m_f[c] = x;
                if (d == 1) sv = 1;
                else if (d == 3) sv = -1;
                else illegal = 1;
            end
            if (illegal) m_err[c] = 1;
            else if (error_clear[c]) m_err[c] = 0;
            if (count_clear[c]) m_cnt[c] = 0;
            else m_cnt[c] = (m_cnt[c] + sv + 65536) % 65536;
            if (term) begin
                m_speed[c] = clampi(m_acc[c] + sv, -(1 << (SW - 1)), (1 << (SW - 1)) - 1);
                m_acc[c] = 0;
            end else begin
                m_acc[c] = clampi(m_acc[c] + sv, -(1 << SW), (1 << SW) - 1);
            end
            m_hist[c].push_back(enc[2*c +: 2]);
            void'(m_hist[c].pop_front());
        end
        m_valid = term ? 1 : 0;
        m_timer = term ? 0 : m_timer + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                chk("model_count", c, int'(enc_count[c*CW +: CW]), m_cnt[c]);
                chk("model_speed", c, int'($signed(speed[c*SW +: SW])), m_speed[c]);
                chk("model_error", c, int'(enc_error[c]), m_err[c]);
            end
            chk("model_valid", -1, int'(speed_valid), m_valid);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic step_ch(input int c, input bit up, input int hold);
        enc[2*c +: 2] = gray_next(enc[2*c +: 2], up);
        tick(hold);
    endtask

    function automatic int cnt_of(input int c);
        return int'(enc_count[c*CW +: CW]);
    endfunction

    function automatic int spd_of(input int c);
        return int'($signed(speed[c*SW +: SW]));
    endfunction

    task automatic wait_valid();
        int n;
        n = 0;
        while (speed_valid !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("wait_valid", -1, int'(speed_valid), 1);
    endtask

    initial begin
        int n;
        tick(2);
        chk("rst_count0", 0, cnt_of(0), 0);
        chk("rst_valid", -1, int'(speed_valid), 0);
        chk("rst_error", -1, int'(enc_error), 0);
        reset = 1'b0;

        // ch0: first step latency, then 7 more UP steps
        enc[1:0] = 2'b01;
        tick(4);
        chk("latency_before", 0, cnt_of(0), 0);
        tick(1);
        chk("latency_at", 0, cnt_of(0), 1);
        tick(5);
        for (int i = 0; i < 7; i++) step_ch(0, 1'b1, 10);
        chk("up8_count0", 0, cnt_of(0), 8);
        chk("up8_count1", 1, cnt_of(1), 0);
        chk("up8_count3", 3, cnt_of(3), 0);
        chk("up8_error", -1, int'(enc_error), 0);

        // ch1: wrap down then back up
        step_ch(1, 1'b0, 10);
        chk("wrap_down", 1, cnt_of(1), 16'hFFFF);
        step_ch(1, 1'b1, 10);
        step_ch(1, 1'b1, 10);
        chk("wrap_up", 1, cnt_of(1), 1);

        // ch2: glitch, illegal, clear, clear colliding with a new illegal
        enc[5:4] = 2'b01;
        tick(2);
        enc[5:4] = 2'b00;
        tick(10);
        chk("glitch_count", 2, cnt_of(2), 0);
        enc[5:4] = 2'b11;
        tick(10);
        chk("illegal_flag", 2, int'(enc_error[2]), 1);
        chk("illegal_count", 2, cnt_of(2), 0);
        error_clear[2] = 1'b1;
        tick(1);
        error_clear[2] = 1'b0;
        chk("err_cleared", 2, int'(enc_error[2]), 0);
        enc[5:4] = 2'b00;
        tick(4);
        error_clear[2] = 1'b1;
        tick(1);
        error_clear[2] = 1'b0;
        chk("err_clear_vs_illegal", 2, int'(enc_error[2]), 1);

        // ch3: 7 UP + 2 DOWN inside one window, then an idle window
        wait_valid();
        for (int i = 0; i < 7; i++) step_ch(3, 1'b1, 6);
        for (int i = 0; i < 2; i++) step_ch(3, 1'b0, 6);
        wait_valid();
        chk("speed_net5", 3, spd_of(3), 5);
        tick(1);
        chk("valid_single", -1, int'(speed_valid), 0);
        wait_valid();
        chk("speed_idle", 3, spd_of(3), 0);

        // ch0: saturation both ways
        for (int i = 0; i < 12; i++) step_ch(0, 1'b1, 6);
        wait_valid();
        chk("sat_pos", 0, spd_of(0), 7);
        for (int i = 0; i < 12; i++) step_ch(0, 1'b0, 6);
        wait_valid();
        chk("sat_neg", 0, spd_of(0), -8);
        chk("sat_count0", 0, cnt_of(0), 8);

        // ch0: count_clear on the accepting edge; speed still sees the step
        enc[1:0] = gray_next(enc[1:0], 1'b1);
        tick(4);
        count_clear[0] = 1'b1;
        tick(1);
        count_clear[0] = 1'b0;
        chk("clear_wins", 0, cnt_of(0), 0);
        wait_valid();
        chk("clear_speed", 0, spd_of(0), 1);

        // async reset mid-window
        tick(30);
        reset = 1'b1;
        #1;
        chk("arst_count1", 1, cnt_of(1), 0);
        chk("arst_error", -1, int'(enc_error), 0);
        chk("arst_speed0", 0, spd_of(0), 0);
        chk("arst_valid", -1, int'(speed_valid), 0);
        tick(3);
        reset = 1'b0;
        n = 0;
        while (speed_valid !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("first_valid_edges", -1, n, WIN);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
